dm_arbiter: RTL and testbench



---
 rtl/dm_arbiter.sv | 107 ++++++++++
 tb/tb_dm_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one single-port synchronous data memory among cores
module dm_arbiter #(
  parameter int reg_width  = 12,
  parameter int core_count = 4,
  parameter int id_width   = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [core_count-1:0]           core_req,
  input  logic [core_count-1:0]           core_we,
  input  logic [core_count*reg_width-1:0] core_addr,
  input  logic [core_count*reg_width-1:0] core_wdata,
  output logic [core_count-1:0]           core_ack,
  output logic [reg_width-1:0]            core_rdata,
  output logic [reg_width-1:0]            mem_addr,
  output logic [reg_width-1:0]            mem_wdata,
  output logic                            mem_we,
  input  logic [reg_width-1:0]            mem_rdata,
  output logic [id_width-1:0]             grant_id,
  output logic                            busy
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0]            state_q, state_d;
  logic [core_count-1:0] ack_q, ack_d;
  logic [reg_width-1:0]  rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
  logic                  we_q, we_d, busy_q, busy_d;
  logic [id_width-1:0]   gid_q, gid_d;
  logic [core_count-1:0] elig;
  logic [id_width-1:0]   idx, pick;
  logic                  found;

  // first eligible core at or after the slot following the last grant; a core in its ack cycle is masked
  always_comb begin
    elig = core_req & ~ack_q;
    idx = gid_q;
    pick = gid_q;
    found = 1'b0;
    for (int k = 1; k <= core_count; k++) begin
      idx = id_width'((int'(gid_q) + k) % core_count);
      if (!found && elig[idx]) begin
        pick = idx;
        found = 1'b1;
      end
    end
  end

  // sequencing: grant in IDLE, one memory cycle in ACCESS, capture read data and acknowledge in RESP
  always_comb begin
    state_d = state_q;
    ack_d = '0;
    rdata_d = rdata_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = 1'b0;
    busy_d = busy_q;
    gid_d = gid_q;
    case (state_q)
      IDLE: if (found) begin
        gid_d = pick;
        addr_d = core_addr[int'(pick)*reg_width +: reg_width];
        wdata_d = core_wdata[int'(pick)*reg_width +: reg_width];
        we_d = core_we[pick];
        busy_d = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: state_d = RESP;
      RESP: begin
        rdata_d = mem_rdata;
        ack_d[gid_q] = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and registered outputs; grant pointer resets to the last core so core 0 wins first
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ack_q <= '0;
      rdata_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
      gid_q <= id_width'(core_count - 1);
    end else begin
      state_q <= state_d;
      ack_q <= ack_d;
      rdata_q <= rdata_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      busy_q <= busy_d;
      gid_q <= gid_d;
    end
  end

  assign core_ack = ack_q;
  assign core_rdata = rdata_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we = we_q;
  assign grant_id = gid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a transaction-level model
module tb_dm_arbiter;
  localparam int W = 12, N = 4, IW = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] core_req = '0, core_we = '0, core_ack;
  logic [N*W-1:0] core_addr = '0, core_wdata = '0;
  logic [W-1:0] core_rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_we, busy;
  logic [IW-1:0] grant_id;
  int n_cmp = 0, n_bad = 0;
  bit [W-1:0] mem [4096];
  bit vld [4096];
  logic [W-1:0] refmem [4096];
  int m_ptr = N - 1, m_left = 0, m_core = 0, m_ack = -1;
  logic m_we = 1'b0;
  logic [W-1:0] m_addr = '0, m_wdata = '0, m_exp = '0;
  logic [N-1:0] hold = '0;
  int g3, grants, viol, last, pend3;

  always #5 clk = ~clk;

  dm_arbiter #(.reg_width(W), .core_count(N), .id_width(IW)) dut (
    .clk(clk), .reset(reset), .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_ack(core_ack),
    .core_rdata(core_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .grant_id(grant_id), .busy(busy)
  );

  function automatic logic [W-1:0] init_val(input logic [W-1:0] a);
    return (a == 12'h0A5) ? 12'h3C7 : W'(a * 7 + 12'h155);
  endfunction

  function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
    return vld[a] ? mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      vld[mem_addr] <= 1'b1;
    end
    mem_rdata <= mem_rd(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // each access occupies three edges: grant, memory cycle, response; writes land in refmem at grant
  task automatic model_edge();
    int a;
    bit done;
    a = m_ack;
    m_ack = -1;
    done = 1'b0;
    if (!reset) begin
      m_left = 0;
      m_ptr = N - 1;
    end else if (m_left == 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!done && core_req[c] && c != a) begin
          done = 1'b1;
          m_ptr = c;
          m_core = c;
          m_we = core_we[c];
          m_addr = core_addr[c*W +: W];
          m_wdata = core_wdata[c*W +: W];
          m_exp = refmem[m_addr];
          if (m_we) refmem[m_addr] = m_wdata;
          m_left = 2;
        end
      end
    end else if (m_left == 2) begin
      m_left = 1;
    end else begin
      m_left = 0;
      m_ack = m_core;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("ack", 32'(core_ack), m_ack >= 0 ? 32'(1 << m_ack) : 32'd0);
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("grant_id", 32'(grant_id), 32'(m_ptr));
    chk("mem_we", 32'(mem_we), 32'(m_left == 2 && m_we));
    if (m_left == 2) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (m_left == 2 && m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    if (m_ack >= 0 && !m_we) chk("rdata", 32'(core_rdata), 32'(m_exp));
    if (m_ack >= 0 && !hold[m_ack]) core_req[m_ack] = 1'b0;
  endtask

  task automatic drive(input int i, input bit r, input bit we, input logic [W-1:0] a, input logic [W-1:0] d);
    core_req[i] = r;
    core_we[i] = we;
    core_addr[i*W +: W] = a;
    core_wdata[i*W +: W] = d;
  endtask

  task automatic rnd_fields(input int i);
    drive(i, core_req[i], 1'($urandom_range(0, 1)), W'(12'h0A0 + $urandom_range(0, 15)), W'($urandom));
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) refmem[a] = init_val(W'(a));
    step();
    step();
    chk("rst_gid", 32'(grant_id), 32'(N - 1));
    chk("rst_rdata", 32'(core_rdata), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    reset = 1'b1;
    // single read by core 1
    drive(1, 1'b1, 1'b0, 12'h0A5, 12'h000);
    step();
    chk("rd_addr", 32'(mem_addr), 32'h0A5);
    chk("rd_we", 32'(mem_we), 32'd0);
    step();
    step();
    chk("rd_ack", 32'(core_ack), 32'b0010);
    chk("rd_data", 32'(core_rdata), 32'h3C7);
    step();
    // single write by core 2, read back by core 0
    drive(2, 1'b1, 1'b1, 12'h010, 12'h5A5);
    step();
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_wdata", 32'(mem_wdata), 32'h5A5);
    step();
    chk("wr_we_once", 32'(mem_we), 32'd0);
    step();
    chk("wr_ack", 32'(core_ack), 32'b0100);
    drive(0, 1'b1, 1'b0, 12'h010, 12'h000);
    step();
    step();
    step();
    chk("rb_ack", 32'(core_ack), 32'b0001);
    chk("rb_data", 32'(core_rdata), 32'h5A5);
    // contention from reset
    reset = 1'b0;
    step();
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, W'(12'h0A0 + i), 12'h000);
    reset = 1'b1;
    for (int s = 1; s <= 12; s++) begin
      step();
      if (s % 3 == 0) chk("cont_order", 32'(core_ack), 32'(1 << (s / 3 - 1)));
    end
    step();
    chk("cont_done", 32'(core_req), 32'd0);
    // fairness: core 0 keeps requesting, core 3 asks once
    hold = 4'b0001;
    drive(0, 1'b1, 1'b0, 12'h0A1, 12'h000);
    step();
    step();
    drive(3, 1'b1, 1'b0, 12'h0A2, 12'h000);
    g3 = 0; grants = 0; viol = 0; last = -1; pend3 = 1;
    for (int s = 0; s < 12; s++) begin
      step();
      if (core_ack != '0) begin
        grants++;
        if (core_ack == 4'b0001 && last == 0 && pend3 != 0) viol++;
        if (core_ack == 4'b1000) begin
          pend3 = 0;
          if (g3 == 0) g3 = grants;
        end
        last = (core_ack == 4'b0001) ? 0 : 1;
      end
    end
    chk("fair_bound", 32'(g3 >= 1 && g3 <= N), 32'd1);
    chk("fair_consec", 32'(viol), 32'd0);
    hold = '0;
    for (int s = 0; s < 6; s++) step();
    // reset during RESP of a core 1 read, then re-served
    drive(1, 1'b1, 1'b0, 12'h0A5, 12'h000);
    step();
    step();
    reset = 1'b0;
    step();
    chk("rmid_ack", 32'(core_ack), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_gid", 32'(grant_id), 32'(N - 1));
    reset = 1'b1;
    step();
    step();
    step();
    chk("rmid_reack", 32'(core_ack), 32'b0010);
    chk("rmid_data", 32'(core_rdata), 32'h3C7);
    step();
    // withdrawn request from core 2 while busy
    drive(0, 1'b1, 1'b0, 12'h0A4, 12'h000);
    step();
    drive(2, 1'b1, 1'b1, 12'h0A3, 12'hABC);
    step();
    core_req[2] = 1'b0;
    pend3 = 0;
    for (int s = 0; s < 6; s++) begin
      step();
      if (core_ack[2]) pend3++;
    end
    chk("wd_ack", 32'(pend3), 32'd0);
    chk("wd_mem", 32'(mem_rd(12'h0A3)), 32'(init_val(12'h0A3)));
    // randomized traffic with occasional resets
    hold = '1;
    for (int s = 0; s < 3000; s++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (m_ack == i) begin
          core_req[i] = ($urandom_range(0, 3) == 0);
          rnd_fields(i);
        end else if (m_left != 0 && m_core == i) begin
          if ($urandom_range(0, 1) == 1) rnd_fields(i);
        end else if (core_req[i]) begin
          if ($urandom_range(0, 19) == 0) core_req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          core_req[i] = 1'b1;
          rnd_fields(i);
        end
      end
      reset = ($urandom_range(0, 99) != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
